// File: rtl/mbist_pkg.sv
// mbist_pkg: controller states, March element codes, phase encoding and per-element rules
package mbist_pkg;
  typedef enum logic [3:0] {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE, S_IDLE} state_t;
  typedef enum logic {PH_RD, PH_WR} phase_t;
  localparam logic [2:0] M0 = 3'd0, M1 = 3'd1, M2 = 3'd2, M3 = 3'd3, M4 = 3'd4, M5 = 3'd5;
  typedef struct packed {
    logic down;
    logic rbit;
  } elem_t;
  function automatic elem_t elem_info(input logic [2:0] e);
    elem_t r;
    r.down = e == M3 || e == M4;
    r.rbit = e == M2 || e == M4;
    return r;
  endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter with load-to-start and end-of-sweep flag
module mbist_addr_gen #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic down;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      addr <= dir ? '1 : '0;
      down <= dir;
    end else if (step)
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
  assign last = down ? addr == '0 : addr == '1;
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer with read-compare and first-failure capture
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter logic [DATA_W-1:0] BG = {DATA_W{1'b0}},
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_bits,
  output logic [CNT_W-1:0]  err_count
);
  state_t state;
  phase_t phase;
  elem_t cur, nxt;
  logic [2:0] elem, cmp_elem;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic unused_info, is_el, rw, rd_op, wr_op, adv, go, last, load, step, dir, cmp_valid, mismatch;
  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .load(load), .step(step), .dir(dir), .addr(mem_addr), .last(last)
  );
  always_comb begin
    elem = state[2:0];
    cur = elem_info(elem);
    nxt = elem_info(elem + 3'd1);
    unused_info = cur.down ^ nxt.rbit;
    is_el = state < S_DRAIN;
    rw = elem inside {M1, M2, M3, M4};
    rd_op = is_el && elem != M0 && (!rw || phase == PH_RD);
    wr_op = is_el && elem != M5 && (!rw || phase == PH_WR);
    adv = is_el && !(rw && phase == PH_RD);
    go = start && (state == S_IDLE || state == S_DONE);
    load = go || (adv && last);
    step = adv && !last;
    dir = !go && nxt.down;
    mismatch = cmp_valid && mem_rdata != cmp_exp;
    mem_we = wr_op;
    mem_re = rd_op;
    mem_wdata = wr_op ? ((rw && !cur.rbit) ? ~BG : BG) : '0;
    busy = is_el || state == S_DRAIN;
    done = state == S_DONE;
    pass = done && !fail;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      phase <= PH_RD;
      cmp_valid <= 1'b0;
      cmp_exp <= '0;
      cmp_addr <= '0;
      cmp_elem <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_bits <= '0;
      err_count <= '0;
    end else begin
      state <= go ? S_M0 : state == S_DRAIN ? S_DONE : (adv && last) ? state_t'(state + 4'd1) : state;
      phase <= (!go && rw && phase == PH_RD) ? PH_WR : PH_RD;
      cmp_valid <= rd_op;
      cmp_exp <= cur.rbit ? ~BG : BG;
      cmp_addr <= mem_addr;
      cmp_elem <= elem;
      if (go) begin
        fail <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_bits <= '0;
        err_count <= '0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!fail) begin
          fail <= 1'b1;
          fail_addr <= cmp_addr;
          fail_elem <= cmp_elem;
          fail_bits <= mem_rdata ^ cmp_exp;
        end
      end
    end
endmodule
